// File: rtl/reg_file_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sequencer_pkg
// Description : Shared opcode constants, instruction field positions, FSM
//               state encoding and decode helpers for the register-file
//               sequencer and its ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_sequencer_pkg;

    // Opcodes carried in INSTR[31:24]
    localparam logic [7:0] c_OP_LOADI = 8'd0;
    localparam logic [7:0] c_OP_MOV   = 8'd1;
    localparam logic [7:0] c_OP_ADD   = 8'd2;
    localparam logic [7:0] c_OP_SUB   = 8'd3;
    localparam logic [7:0] c_OP_AND   = 8'd4;
    localparam logic [7:0] c_OP_OR    = 8'd5;

    // Instruction field LSB positions; register fields are 3 bits wide
    localparam int c_OPC_LSB  = 24;
    localparam int c_DEST_LSB = 16;
    localparam int c_SRC1_LSB = 8;
    localparam int c_SRC2_LSB = 0;

    // Sequencer state encoding
    localparam int                    c_STATE_W = 2;
    localparam logic [c_STATE_W-1:0]  c_ST_IDLE = 2'd0;
    localparam logic [c_STATE_W-1:0]  c_ST_READ = 2'd1;
    localparam logic [c_STATE_W-1:0]  c_ST_EXEC = 2'd2;
    localparam logic [c_STATE_W-1:0]  c_ST_WB   = 2'd3;

    // Function selected inside the ALU
    typedef enum logic [2:0] {
        ALU_PASS_B = 3'd0,
        ALU_ADD    = 3'd1,
        ALU_SUB    = 3'd2,
        ALU_AND    = 3'd3,
        ALU_OR     = 3'd4
    } alu_op_e;

    // The parts of an accepted instruction that live past the handshake.
    // Source addresses are held directly in the read-address registers.
    typedef struct packed {
        logic [7:0] opcode;
        logic [2:0] dest;
        logic [7:0] imm;
    } instr_lat_t;

    function automatic logic is_legal_op(input logic [7:0] op);
        return (op <= c_OP_OR);
    endfunction

    // LOADI and MOV both pass operand B straight through; the top chooses
    // whether B is the immediate or read port 2.
    function automatic alu_op_e alu_op_of(input logic [7:0] op);
        alu_op_e f;
        case (op)
            c_OP_ADD: f = ALU_ADD;
            c_OP_SUB: f = ALU_SUB;
            c_OP_AND: f = ALU_AND;
            c_OP_OR:  f = ALU_OR;
            default:  f = ALU_PASS_B;
        endcase
        return f;
    endfunction

    // Only arithmetic operations are allowed to touch the ZERO flag
    function automatic logic updates_zero(input logic [7:0] op);
        return (op == c_OP_ADD) || (op == c_OP_SUB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sequencer_if
// Description : Instruction handshake plus register-file address/data bus
//               between the sequencer (master) and its environment (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_sequencer_if;

    // Instruction handshake
    logic [31:0] INSTR;
    logic        INSTR_VALID;
    logic        INSTR_READY;

    // Register file read ports
    logic [2:0]  REG_OUT1ADDR;
    logic [2:0]  REG_OUT2ADDR;
    logic [7:0]  REG_OUT1;
    logic [7:0]  REG_OUT2;

    // Register file write port
    logic [2:0]  REG_INADDR;
    logic [7:0]  REG_IN;
    logic        REG_WRITE;

    // Status
    logic        ZERO;
    logic        DONE;
    logic        ILLEGAL;

    modport master (
        input  INSTR, INSTR_VALID, REG_OUT1, REG_OUT2,
        output INSTR_READY, REG_OUT1ADDR, REG_OUT2ADDR,
               REG_INADDR, REG_IN, REG_WRITE, ZERO, DONE, ILLEGAL
    );

    modport slave (
        output INSTR, INSTR_VALID, REG_OUT1, REG_OUT2,
        input  INSTR_READY, REG_OUT1ADDR, REG_OUT2ADDR,
               REG_INADDR, REG_IN, REG_WRITE, ZERO, DONE, ILLEGAL
    );

endinterface
`default_nettype wire

// File: rtl/reg_file_sequencer_alu.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sequencer_alu
// Description : Combinational 8-bit function unit (pass, add, sub, and, or)
//               with a result-is-zero flag. All arithmetic is modulo 256.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_sequencer_alu
    import reg_file_sequencer_pkg::*;
(
    input  wire alu_op_e    i_op,
    input  wire logic [7:0] i_a,
    input  wire logic [7:0] i_b,
    output logic [7:0]      o_result,
    output logic            o_zero
);

    // Select the function; subtraction is two's-complement add of ~B
    always_comb begin
        o_result = i_b;
        case (i_op)
            ALU_ADD:    o_result = i_a + i_b;
            ALU_SUB:    o_result = i_a + ~i_b + 8'd1;
            ALU_AND:    o_result = i_a & i_b;
            ALU_OR:     o_result = i_a | i_b;
            default:    o_result = i_b;
        endcase
        o_zero = (o_result == 8'd0);
    end

endmodule
`default_nettype wire

// File: rtl/reg_file_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sequencer
// Description : Multi-cycle sequencer that accepts one instruction per
//               handshake, reads the register file, computes a result and
//               issues a single registered write-back.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_sequencer
    import reg_file_sequencer_pkg::*;
#(
    parameter int READ_WAIT = 1   // cycles in READ before sampling read data, 1..7
) (
    input  wire logic             CLK,
    input  wire logic             RESET,
    reg_file_sequencer_if.master  bus
);

    localparam logic [2:0] c_WAIT_LAST = 3'(READ_WAIT - 1);

    // State and datapath registers
    logic [c_STATE_W-1:0] r_state;
    instr_lat_t           r_instr;
    logic [2:0]           r_cnt;
    logic [2:0]           r_raddr1;
    logic [2:0]           r_raddr2;
    logic [2:0]           r_waddr;
    logic [7:0]           r_result;
    logic                 r_zero;
    logic                 r_write;
    logic                 r_done;
    logic                 r_illegal;

    // Decoded fields of the instruction currently on the bus
    logic [7:0]           w_opcode;
    logic [2:0]           w_dest;
    logic [2:0]           w_src1;
    logic [2:0]           w_src2;
    logic [7:0]           w_imm;
    logic                 w_unused_instr_bits;

    logic                 w_ready;
    logic                 w_hs;
    alu_op_e              w_alu_op;
    logic [7:0]           w_alu_b;
    logic [7:0]           w_alu_result;
    logic                 w_alu_zero;

    assign w_opcode = bus.INSTR[c_OPC_LSB  +: 8];
    assign w_dest   = bus.INSTR[c_DEST_LSB +: 3];
    assign w_src1   = bus.INSTR[c_SRC1_LSB +: 3];
    assign w_src2   = bus.INSTR[c_SRC2_LSB +: 3];
    assign w_imm    = bus.INSTR[c_SRC2_LSB +: 8];

    // Upper bits of the register fields carry no meaning
    assign w_unused_instr_bits = ^{bus.INSTR[23:19], bus.INSTR[15:11]};

    // Ready only when idle and not being reset; reset must block acceptance
    // in the very cycle it is asserted.
    assign w_ready = (r_state == c_ST_IDLE) && !RESET;
    assign w_hs    = bus.INSTR_VALID && w_ready;

    // LOADI feeds the immediate into the pass-through path instead of port 2
    assign w_alu_op = alu_op_of(r_instr.opcode);
    assign w_alu_b  = (r_instr.opcode == c_OP_LOADI) ? r_instr.imm : bus.REG_OUT2;

    reg_file_sequencer_alu u_alu (
        .i_op     (w_alu_op),
        .i_a      (bus.REG_OUT1),
        .i_b      (w_alu_b),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero)
    );

    // Sequencer FSM, read-wait counter and all registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= c_ST_IDLE;
            r_instr   <= '0;
            r_cnt     <= 3'd0;
            r_raddr1  <= 3'd0;
            r_raddr2  <= 3'd0;
            r_waddr   <= 3'd0;
            r_result  <= 8'd0;
            r_zero    <= 1'b0;
            r_write   <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_write   <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_hs) begin
                        r_instr.opcode <= w_opcode;
                        r_instr.dest   <= w_dest;
                        r_instr.imm    <= w_imm;
                        if (!is_legal_op(w_opcode)) begin
                            // Unknown opcode: report it and stay ready,
                            // leaving the register file untouched.
                            r_illegal <= 1'b1;
                        end else if (w_opcode == c_OP_LOADI) begin
                            r_state <= c_ST_EXEC;
                        end else begin
                            r_raddr1 <= w_src1;
                            r_raddr2 <= w_src2;
                            r_cnt    <= 3'd0;
                            r_state  <= c_ST_READ;
                        end
                    end
                end
                c_ST_READ: begin
                    if (r_cnt == c_WAIT_LAST) begin
                        r_state <= c_ST_EXEC;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                c_ST_EXEC: begin
                    // Read data has settled; capture result and arm the
                    // write so REG_WRITE/INADDR/IN all rise on one edge.
                    r_result <= w_alu_result;
                    r_waddr  <= r_instr.dest;
                    r_write  <= 1'b1;
                    if (updates_zero(r_instr.opcode)) begin
                        r_zero <= w_alu_zero;
                    end
                    r_state <= c_ST_WB;
                end
                c_ST_WB: begin
                    r_done  <= 1'b1;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.INSTR_READY  = w_ready;
    assign bus.REG_OUT1ADDR = r_raddr1;
    assign bus.REG_OUT2ADDR = r_raddr2;
    assign bus.REG_INADDR   = r_waddr;
    assign bus.REG_IN       = r_result;
    // A reset landing on WB must stop the write at the register file edge
    assign bus.REG_WRITE    = r_write && !RESET;
    assign bus.ZERO         = r_zero;
    assign bus.DONE         = r_done;
    assign bus.ILLEGAL      = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_sequencer
// Description : Self-checking bench; two sequencers (READ_WAIT 1 and 3) each
//               drive a behavioural 8x8 register file, checked against an
//               instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_sequencer;

    localparam int OP_LOADI = 0;
    localparam int OP_MOV   = 1;
    localparam int OP_ADD   = 2;
    localparam int OP_SUB   = 3;
    localparam int OP_AND   = 4;
    localparam int OP_OR    = 5;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    int checks   = 0;
    int failures = 0;

    reg_file_sequencer_if if1 ();
    reg_file_sequencer_if if3 ();

    reg_file_sequencer #(.READ_WAIT(1)) dut1 (.CLK(CLK), .RESET(RESET), .bus(if1));
    reg_file_sequencer #(.READ_WAIT(3)) dut3 (.CLK(CLK), .RESET(RESET), .bus(if3));

    always #5 CLK = ~CLK;

    // Behavioural register files (shared reset, combinational read)
    logic [7:0] rf1 [8];
    logic [7:0] rf3 [8];
    int         wr_cnt1 = 0;
    int         wr_cnt3 = 0;

    assign if1.REG_OUT1 = rf1[if1.REG_OUT1ADDR];
    assign if1.REG_OUT2 = rf1[if1.REG_OUT2ADDR];
    assign if3.REG_OUT1 = rf3[if3.REG_OUT1ADDR];
    assign if3.REG_OUT2 = rf3[if3.REG_OUT2ADDR];

    always @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++) rf1[i] <= 8'h00;
        end else if (if1.REG_WRITE) begin
            rf1[if1.REG_INADDR] <= if1.REG_IN;
            wr_cnt1 <= wr_cnt1 + 1;
        end
    end

    always @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++) rf3[i] <= 8'h00;
        end else if (if3.REG_WRITE) begin
            rf3[if3.REG_INADDR] <= if3.REG_IN;
            wr_cnt3 <= wr_cnt3 + 1;
        end
    end

    // Reference model state: architectural registers and ZERO flag
    int   mdl1 [8];
    int   mdl3 [8];
    logic mz1 = 1'b0;

    function automatic int ref_result(int op, int a, int b, int imm);
        case (op)
            OP_LOADI: return imm;
            OP_MOV:   return b;
            OP_ADD:   return (a + b) % 256;
            OP_SUB:   return (a - b + 256) % 256;
            OP_AND:   return a & b;
            OP_OR:    return a | b;
            default:  return -1;
        endcase
    endfunction

    // Build an instruction with random junk in every don't-care bit
    function automatic logic [31:0] mk(int op, int d, int s1, int s2);
        logic [31:0] w;
        w        = $urandom;
        w[31:24] = 8'(op);
        w[18:16] = 3'(d);
        w[10:8]  = 3'(s1);
        if (op == OP_LOADI) w[7:0] = 8'(s2);
        else                w[2:0] = 3'(s2);
        return w;
    endfunction

    // Issue one legal instruction on the READ_WAIT=1 sequencer and check it
    task automatic run1(input logic [31:0] w, input string name, input int want_val);
        int op, a, b, exp, lat_exp, k, wr0;
        logic exp_z;
        logic [2:0] dest;
        op      = int'(w[31:24]);
        a       = mdl1[w[10:8]];
        b       = mdl1[w[2:0]];
        exp     = ref_result(op, a, b, int'(w[7:0]));
        exp_z   = (op == OP_ADD || op == OP_SUB) ? (exp == 0) : mz1;
        // negedges after the handshake edge until the WB cycle is visible
        lat_exp = (op == OP_LOADI) ? 2 : 3;
        dest    = w[18:16];
        wr0     = wr_cnt1;

        if1.INSTR       = w;
        if1.INSTR_VALID = 1'b1;
        k = 0;
        while (!if1.INSTR_READY && k < 20) begin @(negedge CLK); k++; end
        checks++;
        if (if1.INSTR_READY !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_timeout got=%b want=1", name, if1.INSTR_READY);
            if1.INSTR_VALID = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        if1.INSTR_VALID = 1'b0;
        if1.INSTR       = $urandom;

        for (k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (op != OP_LOADI && k == lat_exp - 1) begin
                checks++;
                if (if1.REG_OUT1ADDR !== w[10:8] || if1.REG_OUT2ADDR !== w[2:0]) begin
                    failures++;
                    $display("FAIL %s read_addr got=%0d,%0d want=%0d,%0d", name,
                             if1.REG_OUT1ADDR, if1.REG_OUT2ADDR, w[10:8], w[2:0]);
                end
            end
            if (if1.REG_WRITE === 1'b1) break;
        end
        checks++;
        if (k != lat_exp) begin
            failures++;
            $display("FAIL %s write_latency got=%0d want=%0d", name, k, lat_exp);
        end
        checks++;
        if (if1.REG_INADDR !== dest || if1.REG_IN !== 8'(exp)) begin
            failures++;
            $display("FAIL %s write_data got=r%0d:%02h want=r%0d:%02h", name,
                     if1.REG_INADDR, if1.REG_IN, dest, 8'(exp));
        end
        if (want_val >= 0) begin
            checks++;
            if (if1.REG_IN !== 8'(want_val)) begin
                failures++;
                $display("FAIL %s expected_value got=%02h want=%02h", name, if1.REG_IN, 8'(want_val));
            end
        end
        checks++;
        if (if1.DONE !== 1'b0) begin
            failures++;
            $display("FAIL %s done_early got=%b want=0", name, if1.DONE);
        end

        @(negedge CLK);
        checks++;
        if (if1.REG_WRITE !== 1'b0 || if1.DONE !== 1'b1 || if1.ILLEGAL !== 1'b0 ||
            if1.INSTR_READY !== 1'b1) begin
            failures++;
            $display("FAIL %s after_wb got write=%b done=%b illegal=%b ready=%b want 0,1,0,1",
                     name, if1.REG_WRITE, if1.DONE, if1.ILLEGAL, if1.INSTR_READY);
        end
        checks++;
        if (if1.ZERO !== exp_z) begin
            failures++;
            $display("FAIL %s zero got=%b want=%b", name, if1.ZERO, exp_z);
        end
        checks++;
        if (rf1[dest] !== 8'(exp) || wr_cnt1 != wr0 + 1) begin
            failures++;
            $display("FAIL %s regfile got=%02h writes=%0d want=%02h writes=%0d", name,
                     rf1[dest], wr_cnt1 - wr0, 8'(exp), 1);
        end

        @(negedge CLK);
        checks++;
        if (if1.DONE !== 1'b0) begin
            failures++;
            $display("FAIL %s done_width got=%b want=0", name, if1.DONE);
        end
        mdl1[dest] = exp;
        mz1        = exp_z;
    endtask

    task automatic test_reset;
        if1.INSTR = mk(OP_LOADI, 1, 0, 8'h77); if1.INSTR_VALID = 1'b1;
        if3.INSTR = 32'h0; if3.INSTR_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (if1.INSTR_READY !== 1'b0 || if1.REG_WRITE !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_write got=%b,%b want=0,0", if1.INSTR_READY, if1.REG_WRITE);
        end
        checks++;
        if ({if1.DONE, if1.ILLEGAL, if1.ZERO, if1.REG_OUT1ADDR, if1.REG_OUT2ADDR,
             if1.REG_INADDR, if1.REG_IN} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got done=%b ill=%b z=%b a1=%0d a2=%0d wa=%0d wd=%02h want all 0",
                     if1.DONE, if1.ILLEGAL, if1.ZERO, if1.REG_OUT1ADDR, if1.REG_OUT2ADDR,
                     if1.REG_INADDR, if1.REG_IN);
        end
        RESET = 1'b0; if1.INSTR_VALID = 1'b0;
        @(negedge CLK);
        checks++;
        if (if1.INSTR_READY !== 1'b1 || if1.DONE !== 1'b0 || wr_cnt1 != 0) begin
            failures++;
            $display("FAIL reset_release got ready=%b done=%b writes=%0d want 1,0,0",
                     if1.INSTR_READY, if1.DONE, wr_cnt1);
        end
    endtask

    task automatic test_loadi;
        run1(mk(OP_LOADI, 3, 0, 8'h5A), "loadi_r3", 8'h5A);
    endtask

    task automatic test_alu;
        run1(mk(OP_LOADI, 1, 0, 8'h10), "loadi_r1", 8'h10);
        run1(mk(OP_LOADI, 2, 0, 8'h10), "loadi_r2", 8'h10);
        run1(mk(OP_SUB, 4, 1, 2), "sub_zero", 8'h00);
        run1(mk(OP_ADD, 4, 1, 2), "add", 8'h20);
        run1(mk(OP_MOV, 5, 0, 2), "mov", 8'h10);
        run1(mk(OP_LOADI, 6, 0, 8'hF0), "loadi_r6", 8'hF0);
        run1(mk(OP_LOADI, 7, 0, 8'h20), "loadi_r7", 8'h20);
        run1(mk(OP_ADD, 3, 6, 7), "add_wrap", 8'h10);
        run1(mk(OP_LOADI, 1, 0, 8'hCC), "loadi_cc", 8'hCC);
        run1(mk(OP_LOADI, 2, 0, 8'hAA), "loadi_aa", 8'hAA);
        run1(mk(OP_SUB, 0, 1, 1), "sub_self", 8'h00);
        run1(mk(OP_AND, 3, 1, 2), "and_zero_held", 8'h88);
        run1(mk(OP_OR, 3, 1, 2), "or", 8'hEE);
        run1(mk(OP_ADD, 1, 1, 2), "dest_eq_src", 8'h76);
        run1(mk(OP_SUB, 6, 7, 6), "sub_borrow", 8'h30);
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            int op;
            op = $urandom_range(0, 5);
            run1(mk(op, $urandom_range(0, 7), $urandom_range(0, 7),
                    (op == OP_LOADI) ? $urandom_range(0, 255) : $urandom_range(0, 7)),
                 "random", -1);
        end
    endtask

    task automatic test_illegal(input int opc);
        int wr0, k;
        logic z0;
        wr0 = wr_cnt1;
        z0  = mz1;
        if1.INSTR       = mk(opc, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        if1.INSTR_VALID = 1'b1;
        k = 0;
        while (!if1.INSTR_READY && k < 20) begin @(negedge CLK); k++; end
        @(posedge CLK);
        #1;
        if1.INSTR_VALID = 1'b0;
        @(negedge CLK);
        checks++;
        if (if1.ILLEGAL !== 1'b1 || if1.DONE !== 1'b0 || if1.REG_WRITE !== 1'b0 ||
            if1.INSTR_READY !== 1'b1) begin
            failures++;
            $display("FAIL illegal_%0d pulse got ill=%b done=%b write=%b ready=%b want 1,0,0,1",
                     opc, if1.ILLEGAL, if1.DONE, if1.REG_WRITE, if1.INSTR_READY);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (if1.ILLEGAL !== 1'b0 || if1.DONE !== 1'b0 || if1.REG_WRITE !== 1'b0) begin
                failures++;
                $display("FAIL illegal_%0d quiet got ill=%b done=%b write=%b want 0,0,0",
                         opc, if1.ILLEGAL, if1.DONE, if1.REG_WRITE);
            end
        end
        checks++;
        if (wr_cnt1 != wr0 || if1.ZERO !== z0) begin
            failures++;
            $display("FAIL illegal_%0d side_effects got writes=%0d zero=%b want 0,%b",
                     opc, wr_cnt1 - wr0, if1.ZERO, z0);
        end
    endtask

    task automatic test_reset_in_wb;
        int wr0;
        run1(mk(OP_LOADI, 1, 0, 8'h33), "pre_r1", 8'h33);
        run1(mk(OP_LOADI, 2, 0, 8'h44), "pre_r2", 8'h44);
        wr0 = wr_cnt1;
        if1.INSTR       = mk(OP_ADD, 6, 1, 2);
        if1.INSTR_VALID = 1'b1;
        @(posedge CLK);
        #1;
        if1.INSTR_VALID = 1'b0;
        @(negedge CLK);          // READ
        @(negedge CLK);          // EXEC
        @(posedge CLK);          // enters WB
        #1;
        RESET = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            checks++;
            if (if1.REG_WRITE !== 1'b0 || if1.INSTR_READY !== 1'b0) begin
                failures++;
                $display("FAIL reset_wb_hold got write=%b ready=%b want 0,0",
                         if1.REG_WRITE, if1.INSTR_READY);
            end
        end
        RESET = 1'b0;
        @(negedge CLK);
        checks++;
        if (wr_cnt1 != wr0 || if1.DONE !== 1'b0 || if1.INSTR_READY !== 1'b1) begin
            failures++;
            $display("FAIL reset_wb_after got writes=%0d done=%b ready=%b want 0,0,1",
                     wr_cnt1 - wr0, if1.DONE, if1.INSTR_READY);
        end
        checks++;
        if ({if1.ZERO, if1.REG_INADDR, if1.REG_IN} !== '0) begin
            failures++;
            $display("FAIL reset_wb_outputs got z=%b wa=%0d wd=%02h want 0,0,00",
                     if1.ZERO, if1.REG_INADDR, if1.REG_IN);
        end
        for (int i = 0; i < 8; i++) begin mdl1[i] = 0; mdl3[i] = 0; end
        mz1 = 1'b0;
    endtask

    // VALID held high on the READ_WAIT=3 sequencer; check spacing and order
    task automatic test_back_to_back;
        logic [31:0] prog [$];
        logic [2:0]  qa [$];
        logic [7:0]  qd [$];
        int n, idx, writes, last_hs, prev_op, exp_gap, op, res;
        logic hs;
        logic [31:0] w;
        for (int i = 0; i < 4; i++)
            prog.push_back(mk(OP_LOADI, $urandom_range(0, 7), 0, $urandom_range(0, 255)));
        for (int i = 0; i < 10; i++)
            prog.push_back(mk($urandom_range(1, 5), $urandom_range(0, 7),
                              $urandom_range(0, 7), $urandom_range(0, 7)));
        n = prog.size(); idx = 0; writes = 0; last_hs = -1; prev_op = 0;
        @(negedge CLK);
        if3.INSTR       = prog[0];
        if3.INSTR_VALID = 1'b1;
        for (int cyc = 0; cyc < 400 && writes < n; cyc++) begin
            if (if3.REG_WRITE === 1'b1) begin
                checks++;
                if (qa.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_unexpected_write got=r%0d:%02h want=none",
                             if3.REG_INADDR, if3.REG_IN);
                end else begin
                    if (if3.REG_INADDR !== qa[0] || if3.REG_IN !== qd[0]) begin
                        failures++;
                        $display("FAIL b2b_write got=r%0d:%02h want=r%0d:%02h",
                                 if3.REG_INADDR, if3.REG_IN, qa[0], qd[0]);
                    end
                    void'(qa.pop_front());
                    void'(qd.pop_front());
                end
                writes++;
            end
            hs = if3.INSTR_VALID && if3.INSTR_READY;
            @(posedge CLK);
            if (hs) begin
                if (last_hs >= 0) begin
                    exp_gap = (prev_op == OP_LOADI) ? 3 : 6;
                    checks++;
                    if (cyc - last_hs != exp_gap) begin
                        failures++;
                        $display("FAIL b2b_gap got=%0d want=%0d", cyc - last_hs, exp_gap);
                    end
                end
                w   = prog[idx];
                op  = int'(w[31:24]);
                res = ref_result(op, mdl3[w[10:8]], mdl3[w[2:0]], int'(w[7:0]));
                qa.push_back(w[18:16]);
                qd.push_back(8'(res));
                mdl3[w[18:16]] = res;
                prev_op = op;
                last_hs = cyc;
                idx++;
                #1;
                if (idx < n) if3.INSTR = prog[idx];
                else         if3.INSTR_VALID = 1'b0;
            end
            @(negedge CLK);
        end
        if3.INSTR_VALID = 1'b0;
        checks++;
        if (idx != n || writes != n || wr_cnt3 != n) begin
            failures++;
            $display("FAIL b2b_count got hs=%0d writes=%0d rf_writes=%0d want=%0d",
                     idx, writes, wr_cnt3, n);
        end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (rf3[r] !== 8'(mdl3[r])) begin
                failures++;
                $display("FAIL b2b_reg%0d got=%02h want=%02h", r, rf3[r], 8'(mdl3[r]));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin mdl1[i] = 0; mdl3[i] = 0; end
        test_reset();
        test_loadi();
        test_alu();
        test_random();
        test_illegal(7);
        test_illegal(6);
        test_illegal(255);
        test_illegal($urandom_range(8, 254));
        test_reset_in_wb();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
